// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared types and helpers for the async FIFO read-side controller.
// Holds the output-buffer state encoding and the buffer occupancy helper.
package fifo_rd_ctrl_pkg;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  // Words the buffer will hold once the in-flight read lands and the current pop retires.
  function automatic logic [2:0] buf_occupancy(input buf_state_e s, input logic inflight,
                                               input logic pop);
    logic [2:0] base;
    case (s)
      BUF_EMPTY: base = 3'd0;
      BUF_ONE:   base = 3'd1;
      BUF_TWO:   base = 3'd2;
      default:   base = 3'd2;
    endcase
    return base + {2'b00, inflight} - {2'b00, pop};
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// AXI-Stream link between the FIFO read controller (master) and its consumer (slave).
interface fifo_rd_ctrl_if #(
  parameter int dw = 8
);
  logic          m_tvalid;
  logic [dw-1:0] m_tdata;
  logic          m_tready;

  modport master (output m_tvalid, output m_tdata, input  m_tready);
  modport slave  (input  m_tvalid, input  m_tdata, output m_tready);
endinterface

// File: rtl/fifo_rd_ctrl_gray_conv.sv
// Combinational Gray-to-binary converter shared by the FIFO pointer logic.
// Each binary bit is the XOR of all Gray bits at or above it.
module fifo_gray_conv #(
  parameter int w = 4
) (
  input  logic [w-1:0] i_gray,
  output logic [w-1:0] o_bin
);
  for (genvar i = 0; i < w; i++) begin : g_bit
    assign o_bin[i] = ^i_gray[w-1:i];
  end
endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO: owns the read pointer and empty flag and
// drains the RAM onto AXI-Stream through a 2-entry buffer. Optional macro FIFO_RD_LEVEL_EN adds rd_level.
module fifo_rd_ctrl
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int aw = 3,
  parameter int dw = 8
) (
  input  logic          rclk,
  input  logic          rrst_n,
  input  logic [aw:0]   wptr_gray_sync,
  input  logic [dw-1:0] ram_do,
  output logic [aw-1:0] raddr,
  output logic          rd_en,
  output logic          rce,
  output logic          oe,
  output logic          empty,
  output logic [aw:0]   rptr_gray,
  fifo_rd_ctrl_if.master m_axis
`ifdef FIFO_RD_LEVEL_EN
  ,
  output logic [aw:0]   rd_level
`endif
);

  function automatic logic [aw:0] bin2gray(input logic [aw:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [aw:0]   r_rbin;
  logic [aw:0]   r_rptr_gray;
  logic          r_empty;
  logic          r_inflight;
  logic          r_tvalid;
  logic [dw-1:0] r_head;
  logic [dw-1:0] r_skid;
  buf_state_e    r_state;

  logic [aw:0]   w_wbin;
  logic [aw:0]   w_rbin_next;
  logic          w_pop;
  logic          w_issue;
  buf_state_e    w_state_next;
  logic [dw-1:0] w_head_next;
  logic [dw-1:0] w_skid_next;

  fifo_gray_conv #(.w(aw + 1)) u_wgray (
    .i_gray (wptr_gray_sync),
    .o_bin  (w_wbin)
  );

  // Only issue a read when the buffer is guaranteed a free slot for its return.
  assign w_pop       = r_tvalid & m_axis.m_tready;
  assign w_issue     = ~r_empty & (buf_occupancy(r_state, r_inflight, w_pop) < 3'd2);
  assign w_rbin_next = r_rbin + {{aw{1'b0}}, w_issue};

  // Read pointer, Gray copy for the write domain, empty flag and in-flight marker.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      r_rbin      <= '0;
      r_rptr_gray <= '0;
      r_empty     <= 1'b1;
      r_inflight  <= 1'b0;
    end else begin
      r_rbin      <= w_rbin_next;
      r_rptr_gray <= bin2gray(w_rbin_next);
      r_empty     <= (w_rbin_next == w_wbin);
      r_inflight  <= w_issue;
    end
  end

  // Output buffer next state: the head is what m_tdata shows, skid catches a stalled return.
  always_comb begin
    w_state_next = r_state;
    w_head_next  = r_head;
    w_skid_next  = r_skid;
    case (r_state)
      BUF_EMPTY: begin
        if (r_inflight) begin
          w_head_next  = ram_do;
          w_state_next = BUF_ONE;
        end else begin
          w_state_next = BUF_EMPTY;
        end
      end
      BUF_ONE: begin
        if (r_inflight && !w_pop) begin
          w_skid_next  = ram_do;
          w_state_next = BUF_TWO;
        end else if (r_inflight && w_pop) begin
          w_head_next  = ram_do;
          w_state_next = BUF_ONE;
        end else if (w_pop) begin
          w_state_next = BUF_EMPTY;
        end else begin
          w_state_next = BUF_ONE;
        end
      end
      BUF_TWO: begin
        if (w_pop) begin
          w_head_next  = r_skid;
          w_state_next = BUF_ONE;
        end else begin
          w_state_next = BUF_TWO;
        end
      end
      default: begin
        w_state_next = BUF_EMPTY;
      end
    endcase
  end

  // Output buffer registers; valid is registered from the next buffer state.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      r_state  <= BUF_EMPTY;
      r_head   <= '0;
      r_skid   <= '0;
      r_tvalid <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_head   <= w_head_next;
      r_skid   <= w_skid_next;
      r_tvalid <= (w_state_next != BUF_EMPTY);
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  logic [aw:0] r_rd_level;

  // Words still sitting in RAM, excluding the buffer and any in-flight read.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      r_rd_level <= '0;
    end else begin
      r_rd_level <= w_wbin - r_rbin;
    end
  end

  assign rd_level = r_rd_level;
`endif

  assign raddr           = r_rbin[aw-1:0];
  assign rd_en           = w_issue;
  assign rce             = 1'b1;
  assign oe              = 1'b1;
  assign empty           = r_empty;
  assign rptr_gray       = r_rptr_gray;
  assign m_axis.m_tvalid = r_tvalid;
  assign m_axis.m_tdata  = r_head;

endmodule
